muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit for the MIPS execute stage. Consumes the 4-bit `mul_control` produced by the R-type ALU control decoder together with rs/rt operands. Computes MULT/MULTU/DIV/DIVU into private HI/LO registers and services MTHI/MTLO writes. Drives `busy`, which the pipeline uses to stall instructions until HI/LO are final.

## Interface
Parameters:
- none (operand width fixed at 32, iteration count fixed at 32)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `op_valid`  in  1  start request, sampled on `clk` rising edge
- `mul_control`  in  4  one-hot op: [0]=mult, [1]=multu, [2]=div, [3]=divu
- `src_a`  in  32  rs operand (multiplicand / dividend)
- `src_b`  in  32  rt operand (multiplier / divisor)
- `flush`  in  1  abort in-flight op (exception/branch squash)
- `hi_we`  in  1  MTHI write enable
- `lo_we`  in  1  MTLO write enable
- `wdata`  in  32  MTHI/MTLO data
- `hi`  out  32  HI register, continuously driven
- `lo`  out  32  LO register, continuously driven
- `busy`  out  1  op in flight, HI/LO not yet final
- `done`  out  1  one-cycle pulse, HI/LO updated at the preceding edge

## Operation
- Reset (async, `resetn`=0): state IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0, iteration counter=0, internal operand/remainder regs=0.
- States: IDLE, RUN, FIX.
- IDLE: on an edge with `op_valid`=1, `flush`=0 and `mul_control` exactly one-hot, latch operands and op.
  - Multiply ops with fast multiply compiled in: go to FIX.
  - Otherwise: go to RUN with counter=0.
- IDLE, invalid `mul_control` (zero or multiple bits set): ignored, stays IDLE.
- RUN: one radix-2 step per cycle on operand magnitudes. Signed ops take two's-complement absolute values at accept.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring shift-subtract producing 32-bit quotient and remainder.
  - Counter increments each step; after the 32nd step (counter==31), go to FIX.
- FIX: sign correction, then HI/LO write and return to IDLE.
  - mult: negate the 64-bit product if the signs differ.
  - div: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Results: multiply writes HI=product[63:32], LO=product[31:0]; divide writes LO=quotient, HI=remainder.
- Divisor zero (div or divu): LO=32'hFFFF_FFFF, HI=`src_a` as latched; no sign fixup.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- `op_valid` while not IDLE: ignored; no queueing. Upstream must stall on `busy`.
- `hi_we`/`lo_we`: honoured only in IDLE and only when no op is accepted that edge. `op_valid` has priority; otherwise writes are dropped.
- `flush` in RUN/FIX: next edge returns to IDLE. HI/LO unchanged, no `done`.
- `flush` with `op_valid` in IDLE: op not accepted.

## Timing
- Edge E0 accepts op. Cycle n is the period after edge En.
- Iterative op: `busy`=1 in cycles 0..32. FIX occupies cycle 32. HI/LO written at E33. Cycle 33: `busy`=0, `done`=1. Total latency 33 edges.
- Fast multiply: `busy`=1 in cycle 0 (FIX). HI/LO written at E1. `done`=1 in cycle 1.
- `done` is high for exactly one cycle and never coincides with `busy`=1 of the same op.
- A new op may be accepted at the edge ending the `done` cycle (back-to-back).
- MTHI/MTLO: HI/LO visible on outputs the cycle after the write edge.
- Reset mid-op: outputs go to reset values immediately (asynchronous). No `done` is produced.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: mult/multu use a single 32x32→64 signed/unsigned multiply in FIX, 1-cycle latency. Divide is unchanged.
- Not defined: multiply uses the 32-step shift-add path, 33-cycle latency, identical to divide. No multiplier inferred.

## Test plan
- multu 0xFFFF_FFFF × 0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001. `done` in cycle 33 (cycle 1 with `MULDIV_FAST_MUL_EN`).
- mult −3 × 7 (0xFFFF_FFFD, 0x7) → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
- div −7 / 2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. div 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- divu 100 / 0 → LO=0xFFFF_FFFF, HI=0x64. A second `op_valid` during `busy` is ignored and produces no second `done`.
- MTHI 0x1234 in IDLE, then start divu 9 / 4; assert `flush` in cycle 10 → HI=0x1234, LO unchanged, `busy`=0 from cycle 11, no `done`. Retried divu → LO=2, HI=1.
- `resetn` low during cycle 20 of a div → `hi`/`lo`/`busy`/`done`=0 immediately. After release, a new mult 5 × 6 gives LO=30, HI=0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Operand, control and HI/LO result bundle between the execute stage and
// muldiv_unit.
interface muldiv_unit_if;
   logic        op_valid;
   logic [3:0]  mul_control;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   modport master (
      output op_valid, mul_control, src_a, src_b, flush, hi_we, lo_we, wdata,
      input  hi, lo, busy, done
   );

   modport slave (
      input  op_valid, mul_control, src_a, src_b, flush, hi_we, lo_we, wdata,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with private HI/LO and MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module muldiv_unit (
   input logic          clk,
   input logic          resetn,
   muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST_MUL = 1'b1;
`else
   localparam bit FAST_MUL = 1'b0;
`endif

   state_t      state, state_next;
   logic [4:0]  cnt;
   logic        is_mul;
   logic        neg_quo;
   logic        neg_rem;
   logic [31:0] a_raw;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [63:0] acc;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   logic        accept;
   logic        op_signed;
   logic        op_mul;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   logic [32:0] div_diff;
   logic [63:0] div_step;
   logic [63:0] mul_mag;
   logic [63:0] mul_res;
   logic [31:0] quo_res;
   logic [31:0] rem_res;

   assign op_signed = bus.mul_control[0] | bus.mul_control[2];
   assign op_mul    = bus.mul_control[0] | bus.mul_control[1];
   assign accept    = (state == IDLE) && bus.op_valid && !bus.flush &&
                      $onehot(bus.mul_control);
   assign abs_a     = (op_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
   assign abs_b     = (op_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
   assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
   assign mul_step = {mul_sum, acc[31:1]};

   // Divide: acc = {remainder, remaining dividend bits}; the shifted-out
   // remainder needs 33 bits for the trial subtraction.
   assign div_diff = acc[63:31] - {1'b0, b_mag};
   assign div_step = div_diff[32] ? {acc[62:0], 1'b0}
                                  : {div_diff[31:0], acc[30:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
   assign mul_mag = {32'd0, a_mag} * {32'd0, b_mag};
`else
   assign mul_mag = acc;
`endif

   assign mul_res = neg_quo ? -mul_mag : mul_mag;
   assign quo_res = neg_quo ? -acc[31:0] : acc[31:0];
   assign rem_res = neg_rem ? -acc[63:32] : acc[63:32];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // NOTE: defaulting state_next before the case keeps every path assigned,
   // so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = (FAST_MUL && op_mul) ? FIX : RUN;
         RUN:     if (bus.flush) state_next = IDLE;
                  else if (cnt == 5'd31) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt     <= 5'd0;
         is_mul  <= 1'b0;
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
         a_raw   <= 32'd0;
         a_mag   <= 32'd0;
         b_mag   <= 32'd0;
         acc     <= 64'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt     <= 5'd0;
                  is_mul  <= op_mul;
                  neg_quo <= op_signed && (bus.src_a[31] ^ bus.src_b[31]);
                  neg_rem <= op_signed && bus.src_a[31];
                  a_raw   <= bus.src_a;
                  a_mag   <= abs_a;
                  b_mag   <= abs_b;
                  acc     <= {32'd0, op_mul ? abs_b : abs_a};
               end else begin
                  if (bus.hi_we) hi_q <= bus.wdata;
                  if (bus.lo_we) lo_q <= bus.wdata;
               end
            end
            RUN: begin
               if (!bus.flush) begin
                  acc <= is_mul ? mul_step : div_step;
                  cnt <= cnt + 5'd1;
               end
            end
            FIX: begin
               if (!bus.flush) begin
                  done_q <= 1'b1;
                  if (is_mul) begin
                     hi_q <= mul_res[63:32];
                     lo_q <= mul_res[31:0];
                  end else if (b_mag == 32'd0) begin
                     hi_q <= a_raw;
                     lo_q <= 32'hFFFF_FFFF;
                  end else begin
                     hi_q <= rem_res;
                     lo_q <= quo_res;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = (state != IDLE);
   assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model compared every
// cycle, plus literal expectations; honours MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic clk    = 1'b0;
   logic resetn = 1'b1;

   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int errors    = 0;
   int checks    = 0;
   int dut_dones = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference arithmetic straight from the instruction definitions.
   function automatic void model_op(input logic [3:0] mc, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] h,
                                    output logic [31:0] l);
      logic [63:0] p;
      int          sa, sb;
      sa = a;
      sb = b;
      h  = 32'd0;
      l  = 32'd0;
      if (mc[0]) begin
         p = longint'(sa) * longint'(sb);
         h = p[63:32];
         l = p[31:0];
      end else if (mc[1]) begin
         p = {32'd0, a} * {32'd0, b};
         h = p[63:32];
         l = p[31:0];
      end else if (b == 32'd0) begin
         h = a;
         l = 32'hFFFF_FFFF;
      end else if (mc[2]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            h = 32'd0;
            l = 32'h8000_0000;
         end else begin
            l = sa / sb;
            h = sa % sb;
         end
      end else begin
         l = a / b;
         h = a % b;
      end
   endfunction

   // Transaction-level model: remaining cycles of the op in flight.
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        m_done = 1'b0;
   int          m_left = 0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_hi   = '0;
         m_lo   = '0;
         m_done = 1'b0;
         m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_left != 0) begin
            if (bus.flush) m_left = 0;
            else begin
               m_left--;
               if (m_left == 0) begin
                  m_hi   = p_hi;
                  m_lo   = p_lo;
                  m_done = 1'b1;
               end
            end
         end else if (bus.op_valid && !bus.flush && $countones(bus.mul_control) == 1) begin
            model_op(bus.mul_control, bus.src_a, bus.src_b, p_hi, p_lo);
            m_left = (bus.mul_control[0] || bus.mul_control[1]) ? MUL_LAT : DIV_LAT;
         end else begin
            if (bus.hi_we) m_hi = bus.wdata;
            if (bus.lo_we) m_lo = bus.wdata;
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_hi",   bus.hi,            m_hi);
      check("cyc_lo",   bus.lo,            m_lo);
      check("cyc_busy", {31'd0, bus.busy}, {31'd0, m_left != 0});
      check("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
      if (bus.done) dut_dones++;
   end

   task automatic clear_inputs();
      bus.op_valid    = 1'b0;
      bus.mul_control = 4'd0;
      bus.src_a       = 32'd0;
      bus.src_b       = 32'd0;
      bus.flush       = 1'b0;
      bus.hi_we       = 1'b0;
      bus.lo_we       = 1'b0;
      bus.wdata       = 32'd0;
   endtask

   // Called at a negedge; returns at the negedge of cycle 0.
   task automatic start_op(input logic [3:0] mc, input logic [31:0] a, input logic [31:0] b);
      bus.op_valid    = 1'b1;
      bus.mul_control = mc;
      bus.src_a       = a;
      bus.src_b       = b;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic wait_done(input string name, input int elapsed, input int lat,
                            input logic [31:0] e_hi, input logic [31:0] e_lo);
      int n;
      n = elapsed;
      while (!bus.done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_lat"}, n, lat);
      check({name, "_hi"}, bus.hi, e_hi);
      check({name, "_lo"}, bus.lo, e_lo);
   endtask

   initial begin
      clear_inputs();
      #2 resetn = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_hi",   bus.hi,            32'd0);
      check("rst_lo",   bus.lo,            32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      start_op(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu_max", 0, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
      // Back-to-back: each next op is presented during the previous done cycle.
      start_op(4'b0001, 32'hFFFF_FFFD, 32'h0000_0007);
      wait_done("mult_neg", 0, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      start_op(4'b0100, 32'hFFFF_FFF9, 32'h0000_0002);
      wait_done("div_neg", 0, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      start_op(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 0, DIV_LAT, 32'h0000_0000, 32'h8000_0000);

      start_op(4'b1000, 32'd100, 32'd0);
      repeat (4) @(negedge clk);
      start_op(4'b0001, 32'd5, 32'd6);
      wait_done("divu_zero", 5, DIV_LAT, 32'h0000_0064, 32'hFFFF_FFFF);
      repeat (40) @(negedge clk);
      check("ignored_op_dones", dut_dones, 32'd5);

      bus.hi_we = 1'b1;
      bus.wdata = 32'h0000_1234;
      @(negedge clk);
      clear_inputs();
      check("mthi", bus.hi, 32'h0000_1234);
      start_op(4'b1000, 32'd9, 32'd4);
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      clear_inputs();
      check("flush_busy", {31'd0, bus.busy}, 32'd0);
      check("flush_hi",   bus.hi,            32'h0000_1234);
      check("flush_lo",   bus.lo,            32'hFFFF_FFFF);
      repeat (40) @(negedge clk);
      check("flush_dones", dut_dones, 32'd5);
      start_op(4'b1000, 32'd9, 32'd4);
      wait_done("divu_retry", 0, DIV_LAT, 32'd1, 32'd2);

      // Invalid control with MTLO: op dropped, write honoured.
      @(negedge clk);
      bus.op_valid    = 1'b1;
      bus.mul_control = 4'b0011;
      bus.lo_we       = 1'b1;
      bus.wdata       = 32'h0000_ABCD;
      @(negedge clk);
      clear_inputs();
      check("bad_ctl_busy", {31'd0, bus.busy}, 32'd0);
      check("mtlo",         bus.lo,            32'h0000_ABCD);
      bus.op_valid    = 1'b1;
      bus.mul_control = 4'b0010;
      bus.flush       = 1'b1;
      @(negedge clk);
      clear_inputs();
      check("flush_idle_busy", {31'd0, bus.busy}, 32'd0);

      // Accepted op wins over a same-edge MTHI; reset lands mid-divide.
      bus.hi_we = 1'b1;
      bus.wdata = 32'h0000_DEAD;
      start_op(4'b0100, 32'hFFFF_FFF9, 32'd2);
      check("op_over_mthi", bus.hi, 32'd1);
      repeat (20) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_hi",   bus.hi,            32'd0);
      check("mid_rst_lo",   bus.lo,            32'd0);
      check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("mid_rst_done", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      #2 resetn = 1'b1;
      @(negedge clk);
      start_op(4'b0001, 32'd5, 32'd6);
      wait_done("mult_after_rst", 0, MUL_LAT, 32'd0, 32'd30);
      repeat (5) @(negedge clk);
      check("total_dones", dut_dones, 32'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
